imem_loader: RTL

//  Write-side companion to the instruction memory. Receives a framed byte stream
//  (valid/ready), assembles little-endian 32-bit instruction words and writes them

---
 rtl/imem_loader.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : imem_loader
//  Purpose  : Receives a framed byte stream (word count, little-endian payload,
//             XOR checksum), writes the assembled 32-bit words into instruction
//             memory and holds the core in reset until a verified image lands.
//  Revision : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 1024,
    parameter int BASE_ADDR = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             core_hold,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [15:0]      words_written
);

    localparam logic [2:0] c_s_idle   = 3'd0;
    localparam logic [2:0] c_s_hdr_lo = 3'd1;
    localparam logic [2:0] c_s_hdr_hi = 3'd2;
    localparam logic [2:0] c_s_data   = 3'd3;
    localparam logic [2:0] c_s_csum   = 3'd4;
    localparam logic [2:0] c_s_done   = 3'd5;
    localparam logic [2:0] c_s_err    = 3'd6;

    localparam logic [WIDTH-1:0] c_base_addr = WIDTH'(BASE_ADDR);
    // One extra bit so a word count above a 16-bit DEPTH still compares correctly
    localparam logic [16:0]      c_depth     = 17'(DEPTH);

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [7:0]       r_n_lo;
    logic [15:0]      r_n;
    logic [7:0]       r_csum;
    logic [1:0]       r_byte_idx;
    logic [23:0]      r_asm;
    logic [15:0]      r_words;
    logic             r_mem_we;
    logic [WIDTH-1:0] r_mem_addr;
    logic [31:0]      r_mem_wdata;
    logic             r_core_hold;
    logic             r_error;

    logic             w_accept;
    logic [15:0]      w_n_hdr;
    logic             w_word_done;
    logic             w_last_word;

    assign w_accept    = in_valid && in_ready;
    assign w_n_hdr     = {in_data, r_n_lo};
    assign w_word_done = (r_state == c_s_data) && w_accept && (r_byte_idx == 2'd3);
    assign w_last_word = w_word_done && (r_words == (r_n - 16'd1));

    assign mem_we        = r_mem_we;
    assign mem_addr      = r_mem_addr;
    assign mem_wdata     = r_mem_wdata;
    assign core_hold     = r_core_hold;
    assign error         = r_error;
    assign words_written = r_words;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_s_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; DONE and ERR each last exactly one cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_s_idle:   if (start) w_state_nxt = c_s_hdr_lo;
            c_s_hdr_lo: if (w_accept) w_state_nxt = c_s_hdr_hi;
            c_s_hdr_hi: begin
                if (w_accept) begin
                    if ({1'b0, w_n_hdr} > c_depth) begin
                        w_state_nxt = c_s_err;
                    end else if (w_n_hdr == 16'd0) begin
                        w_state_nxt = c_s_csum;
                    end else begin
                        w_state_nxt = c_s_data;
                    end
                end
            end
            c_s_data:   if (w_last_word) w_state_nxt = c_s_csum;
            c_s_csum: begin
                if (w_accept) begin
                    w_state_nxt = (in_data == r_csum) ? c_s_done : c_s_err;
                end
            end
            c_s_done:   w_state_nxt = c_s_idle;
            c_s_err:    w_state_nxt = c_s_idle;
            default:    w_state_nxt = c_s_idle;
        endcase
    end

    // State-decoded handshake and status outputs
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (r_state)
            c_s_hdr_lo, c_s_hdr_hi, c_s_data, c_s_csum: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            c_s_done: done = 1'b1;
            default: begin
                in_ready = 1'b0;
                busy     = 1'b0;
                done     = 1'b0;
            end
        endcase
    end

    // Header capture, word assembly, memory write port, checksum and status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_n_lo      <= 8'd0;
            r_n         <= 16'd0;
            r_csum      <= 8'd0;
            r_byte_idx  <= 2'd0;
            r_asm       <= 24'd0;
            r_words     <= 16'd0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= c_base_addr;
            r_mem_wdata <= 32'd0;
            r_core_hold <= 1'b1;
            r_error     <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;

            if ((r_state == c_s_idle) && start) begin
                r_error     <= 1'b0;
                r_words     <= 16'd0;
                r_csum      <= 8'd0;
                r_byte_idx  <= 2'd0;
                r_core_hold <= 1'b1;
            end

            // The checksum byte itself is not folded into the running XOR
            if (w_accept && (r_state != c_s_csum)) begin
                r_csum <= r_csum ^ in_data;
            end

            if ((r_state == c_s_hdr_lo) && w_accept) begin
                r_n_lo <= in_data;
            end

            if ((r_state == c_s_hdr_hi) && w_accept) begin
                r_n <= w_n_hdr;
            end

            if ((r_state == c_s_data) && w_accept) begin
                r_byte_idx <= r_byte_idx + 2'd1;
                case (r_byte_idx)
                    2'd0:    r_asm[7:0]   <= in_data;
                    2'd1:    r_asm[15:8]  <= in_data;
                    2'd2:    r_asm[23:16] <= in_data;
                    default: begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= c_base_addr + WIDTH'({r_words, 2'b00});
                        r_mem_wdata <= {in_data, r_asm};
                        r_words     <= r_words + 16'd1;
                    end
                endcase
            end

            if (w_state_nxt == c_s_done) begin
                r_core_hold <= 1'b0;
            end

            if ((w_state_nxt == c_s_err) && (r_state != c_s_err)) begin
                r_error <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
